// File: rtl/seg_pkg.sv
// seg_pkg: shared segment types, hex glyph constants and scan FSM states.
//   seg_t        7-bit segment vector {g,f,e,d,c,b,a}, active-high
//   SEG_BLANK    all segments off
//   SEG_0..SEG_F standard hex glyphs (b and d lowercase)
//   scan_state_e BLANK (anti-ghosting gap) / DRIVE (digit lit)
package seg_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;
    localparam seg_t SEG_A = 7'h77;
    localparam seg_t SEG_B = 7'h7C;
    localparam seg_t SEG_C = 7'h39;
    localparam seg_t SEG_D = 7'h5E;
    localparam seg_t SEG_E = 7'h79;
    localparam seg_t SEG_F = 7'h71;
    typedef enum logic {BLANK, DRIVE} scan_state_e;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hex_glyph_decode.sv
// hex_glyph_decode: combinational hex nibble to active-high seven-segment glyph.
//   i_nibble  in  4  hex digit 0-F
//   o_seg     out 7  {g,f,e,d,c,b,a}, active-high
module hex_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            default: o_seg = SEG_F;
        endcase
    end
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed N-digit hex seven-segment display driver.
//   i_clk            in  1      system clock, rising edge
//   i_rst            in  1      asynchronous active-high reset
//   i_value          in  4*N    hex digits, digit 0 in the low nibble
//   i_load           in  1      capture i_value, i_dp_in, i_blank_mask
//   i_dp_in          in  N      decimal point request per digit
//   i_blank_mask     in  N      1 = force digit dark (dp included)
//   i_suppress_zeros in  1      live: blank leading zeros above digit 0
//   o_segment        out 7      {g,f,e,d,c,b,a}, registered, polarity per ACTIVE_LOW
//   o_dp_out         out 1      decimal point, registered
//   o_digit_en       out N      one-hot or all-off digit enable, registered
//   o_frame_done     out 1      pulse on the last cycle the last digit is driven
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DRIVE_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic                      i_load,
    input  logic [NUM_DIGITS-1:0]     i_dp_in,
    input  logic [NUM_DIGITS-1:0]     i_blank_mask,
    input  logic                      i_suppress_zeros,
    output logic [6:0]                o_segment,
    output logic                      o_dp_out,
    output logic [NUM_DIGITS-1:0]     o_digit_en,
    output logic                      o_frame_done
);
    localparam int IDX_W = clog2_min1(NUM_DIGITS);
    localparam int CNT_W = clog2_min1(DRIVE_CYCLES > BLANK_CYCLES ? DRIVE_CYCLES : BLANK_CYCLES);
    localparam logic INV = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_mask;
    scan_state_e             r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [6:0]              r_pat;
    logic                    r_pat_dp;

    scan_state_e             w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_capture;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [3:0]              w_nibble;
    logic                    w_upper_zero;
    logic                    w_dark;
    logic                    w_dp_req;
    logic                    w_masked;
    logic [6:0]              w_glyph;

    hex_glyph_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_value <= '0;
            r_dp    <= '0;
            r_mask  <= '0;
        end else if (i_load) begin
            r_value <= i_value;
            r_dp    <= i_dp_in;
            r_mask  <= i_blank_mask;
        end
    end

    // Select the current digit and decide whether it is a leading zero:
    // every nibble from idx upward must be zero.
    always_comb begin
        w_sel        = '0;
        w_nibble     = 4'h0;
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_sel[i] = (r_idx == IDX_W'(i));
            if (w_sel[i]) w_nibble = r_value[4*i +: 4];
            if (IDX_W'(i) >= r_idx && r_value[4*i +: 4] != 4'h0) w_upper_zero = 1'b0;
        end
        w_masked = |(r_mask & w_sel);
        w_dp_req = |(r_dp & w_sel);
        w_dark   = w_masked | (i_suppress_zeros & (r_idx != '0) & w_upper_zero);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_idx_nxt    = r_idx;
        w_capture    = 1'b0;
        o_frame_done = 1'b0;
        if (r_state == BLANK && r_cnt == BLANK_LAST) begin
            w_state_nxt = DRIVE;
            w_cnt_nxt   = '0;
            w_capture   = 1'b1;
        end
        if (r_state == DRIVE && r_cnt == DRIVE_LAST) begin
            w_state_nxt  = BLANK;
            w_cnt_nxt    = '0;
            w_idx_nxt    = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            o_frame_done = (r_idx == IDX_LAST);
        end
    end

    // Pattern is frozen at entry to DRIVE so a mid-digit load cannot tear the glyph.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pat    <= SEG_BLANK;
            r_pat_dp <= 1'b0;
        end else if (w_capture) begin
            r_pat    <= w_dark ? SEG_BLANK : w_glyph;
            r_pat_dp <= w_dp_req & ~w_masked;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_segment  <= {7{INV}};
            o_dp_out   <= INV;
            o_digit_en <= {NUM_DIGITS{INV}};
        end else begin
            o_segment  <= ((r_state == DRIVE) ? r_pat : SEG_BLANK) ^ {7{INV}};
            o_dp_out   <= ((r_state == DRIVE) & r_pat_dp) ^ INV;
            o_digit_en <= ((r_state == DRIVE) ? w_sel : '0) ^ {NUM_DIGITS{INV}};
        end
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed and randomized checks of the scanner in both polarities.
module tb_seven_segment_scanner;
    localparam int N  = 4;
    localparam int D  = 8;
    localparam int B  = 2;
    localparam int SL = B + D;
    localparam int P  = N * SL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        sz = 1'b0;
    logic [6:0]  seg, seg_h;
    logic        dp, dp_h, fd, fd_h;
    logic [3:0]  en, en_h;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seven_segment_scanner #(.NUM_DIGITS(N), .DRIVE_CYCLES(D), .BLANK_CYCLES(B), .ACTIVE_LOW(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load), .i_dp_in(dp_in),
        .i_blank_mask(blank_mask), .i_suppress_zeros(sz),
        .o_segment(seg), .o_dp_out(dp), .o_digit_en(en), .o_frame_done(fd));

    seven_segment_scanner #(.NUM_DIGITS(N), .DRIVE_CYCLES(D), .BLANK_CYCLES(B), .ACTIVE_LOW(0)) dut_h (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load), .i_dp_in(dp_in),
        .i_blank_mask(blank_mask), .i_suppress_zeros(sz),
        .o_segment(seg_h), .o_dp_out(dp_h), .o_digit_en(en_h), .o_frame_done(fd_h));

    // Reference model: the scan is a fixed timeline of period P after reset,
    // so position within the frame is pure arithmetic on the edge count.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         mk;
    logic [15:0] mv;
    logic [3:0]  mdp, mmask, een;
    logic [6:0]  mpat, eseg;
    logic        mpdp, edp;

    always @(posedge clk or posedge rst) begin : model
        int s0, s1, d;
        logic dark;
        if (rst) begin
            mk <= 0; mv <= '0; mdp <= '0; mmask <= '0;
            mpat <= '0; mpdp <= 1'b0; eseg <= '0; edp <= 1'b0; een <= '0;
        end else begin
            s0 = mk % P;
            s1 = (mk + 1) % P;
            eseg <= (s0 % SL >= B) ? mpat : 7'h00;
            edp  <= (s0 % SL >= B) ? mpdp : 1'b0;
            een  <= (s0 % SL >= B) ? 4'(1 << (s0 / SL)) : 4'h0;
            if (s1 % SL == B) begin
                d = s1 / SL;
                dark = mmask[d] || (sz && d > 0 && (mv >> (4 * d)) == 0);
                mpat <= dark ? 7'h00 : glyph[4'(mv >> (4 * d))];
                mpdp <= mdp[d] && !mmask[d];
            end
            if (load) begin
                mv <= value; mdp <= dp_in; mmask <= blank_mask;
            end
            mk <= mk + 1;
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] m);
        @(negedge clk);
        value = v; dp_in = p; blank_mask = m; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Returns at the negedge sample of the first cycle digit d is enabled.
    task automatic wait_digit(input int d, output bit found);
        logic [3:0] t = ~4'(1 << d);
        logic [3:0] prev = en;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (en == t && prev != t) found = 1'b1;
            prev = en;
        end
    endtask

    task automatic test_reset;
        bit f;
        int n;
        #1;
        n_checks++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else n_pass++;
        n_checks++; if (en !== 4'hF || dp !== 1'b1) $display("FAIL reset_en_dp: got %h/%b want f/1", en, dp); else n_pass++;
        n_checks++; if (en_h !== 4'h0 || seg_h !== 7'h00 || dp_h !== 1'b0) $display("FAIL reset_high: got %h/%h/%b want 0", en_h, seg_h, dp_h); else n_pass++;
        @(negedge clk); rst = 1'b0;
        wait_digit(2, f);
        n_checks++; if (!f) $display("FAIL reset_reach_d2: got timeout want digit 2"); else n_pass++;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (seg !== 7'h7F || en !== 4'hF) $display("FAIL reset_mid_drive: got %h/%h want 7f/f", seg, en); else n_pass++;
        n_checks++; if (fd !== 1'b0 || dp !== 1'b1) $display("FAIL reset_mid_fd_dp: got %b/%b want 0/1", fd, dp); else n_pass++;
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            @(posedge clk); #1;
            if (en == 4'hE) n = i;
        end
        n_checks++; if (n != 3) $display("FAIL reset_first_en: got %0d edges want 3", n); else n_pass++;
    endtask

    task automatic test_full_scan;
        logic [6:0] ex [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        logic [3:0] t;
        bit f;
        int n, m, c, ch;
        sz = 1'b0;
        do_load(16'h1234, 4'h0, 4'h0);
        wait_digit(3, f);
        wait_digit(0, f);
        n_checks++; if (!f) $display("FAIL scan_start: got timeout want digit 0"); else n_pass++;
        for (int d = 0; d < 4; d++) begin
            t = ~4'(1 << d);
            n_checks++; if (en !== t) $display("FAIL scan_en_d%0d: got %h want %h", d, en, t); else n_pass++;
            n_checks++; if (seg !== ex[d] || dp !== 1'b1) $display("FAIL scan_seg_d%0d: got %b/%b want %b/1", d, seg, dp, ex[d]); else n_pass++;
            n_checks++; if (seg_h !== ~ex[d] || dp_h !== 1'b0 || en_h !== ~t) $display("FAIL polarity_d%0d: got %b/%b/%h want %b/0/%h", d, seg_h, dp_h, en_h, ~ex[d], ~t); else n_pass++;
            n = 1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (en == t) n++; else break;
            end
            n_checks++; if (n != D) $display("FAIL scan_drive_len_d%0d: got %0d want %0d", d, n, D); else n_pass++;
            m = 0;
            for (int i = 0; i < 20; i++) begin
                if (en == 4'hF && seg == 7'h7F) begin m++; @(negedge clk); end else break;
            end
            n_checks++; if (m != B) $display("FAIL scan_gap_len_d%0d: got %0d want %0d", d, m, B); else n_pass++;
        end
        c = 0; ch = 0;
        for (int i = 0; i < P; i++) begin
            c += int'(fd); ch += int'(fd_h);
            @(negedge clk);
        end
        n_checks++; if (c != 1 || ch != 1) $display("FAIL frame_done_count: got %0d/%0d want 1/1", c, ch); else n_pass++;
    endtask

    task automatic test_zero_suppress;
        logic [6:0] ex5 [4] = '{7'b1000000, 7'b0010010, 7'h7F, 7'h7F};
        bit f;
        sz = 1'b1;
        do_load(16'h0050, 4'h0, 4'h0);
        wait_digit(3, f);
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, f);
            n_checks++; if (!f || seg !== ex5[d] || dp !== 1'b1) $display("FAIL zs_0050_d%0d: got %b/%b found=%b want %b/1", d, seg, dp, f, ex5[d]); else n_pass++;
        end
        do_load(16'h0000, 4'h0, 4'h0);
        wait_digit(3, f);
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, f);
            n_checks++; if (!f || seg !== (d == 0 ? 7'b1000000 : 7'h7F)) $display("FAIL zs_0000_d%0d: got %b found=%b", d, seg, f); else n_pass++;
        end
        sz = 1'b0;
    endtask

    task automatic test_mask_dp;
        logic [6:0] exs [4] = '{7'b0001110, 7'b0001110, 7'h7F, 7'b0001110};
        logic       exd [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit f;
        do_load(16'hFFFF, 4'b0110, 4'b0100);
        wait_digit(3, f);
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, f);
            n_checks++; if (!f || seg !== exs[d] || dp !== exd[d]) $display("FAIL mask_dp_d%0d: got %b/%b found=%b want %b/%b", d, seg, dp, f, exs[d], exd[d]); else n_pass++;
        end
    endtask

    task automatic test_mid_load;
        bit f;
        int n, bad;
        do_load(16'h0000, 4'h0, 4'h0);
        wait_digit(3, f);
        wait_digit(0, f);
        repeat (3) @(negedge clk);
        value = 16'h000A; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0; bad = 0;
        for (int i = 0; i < 20 && en == 4'hE; i++) begin
            n++;
            if (seg !== 7'b1000000) bad++;
            @(negedge clk);
        end
        n_checks++; if (bad != 0 || n != D - 4) $display("FAIL mid_load_hold: got %0d bad of %0d cycles want 0 of %0d", bad, n, D - 4); else n_pass++;
        wait_digit(0, f);
        n_checks++; if (!f || seg !== 7'b0001000) $display("FAIL mid_load_next: got %b want 0001000", seg); else n_pass++;
    endtask

    task automatic test_random;
        logic [15:0] v;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            n_checks++; if (seg !== ~eseg || seg_h !== eseg) $display("FAIL rnd_seg @%0d: got %b/%b want %b", i, seg, seg_h, eseg); else n_pass++;
            n_checks++; if (dp !== ~edp || dp_h !== edp) $display("FAIL rnd_dp @%0d: got %b/%b want %b", i, dp, dp_h, edp); else n_pass++;
            n_checks++; if (en !== ~een || en_h !== een) $display("FAIL rnd_en @%0d: got %h/%h want %h", i, en, en_h, een); else n_pass++;
            n_checks++; if (fd !== ((mk % P) == P - 1) || fd_h !== fd) $display("FAIL rnd_fd @%0d: got %b/%b want %b", i, fd, fd_h, (mk % P) == P - 1); else n_pass++;
            load = ($urandom_range(0, 15) == 0);
            if (load) begin
                v = 16'($urandom);
                value = v >> (4 * $urandom_range(0, 4));
                dp_in = 4'($urandom);
                blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
            if ($urandom_range(0, 30) == 0) sz = ~sz;
        end
        load = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_full_scan();
        test_zero_suppress();
        test_mask_dp();
        test_mid_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
